arbitru_sram: RTL and testbench

Two-port arbiter and sequencer for the shared 8-location asynchronous SRAM used by the memory path. Port A is the producer/writer side and port B is the transcoder side; either port can read or write. The block grants one request at a time and owns every SRAM strobe: address, chip-enable, write-enable, output-enable and the tristate data bus. It sits between the requesters and the external SRAM pins, replacing direct enable-driven access.

---
 rtl/memorie_pkg.sv | 18 +
 rtl/arbitru_rr.sv | 34 +++
 rtl/arbitru_sram.sv | 159 +++++++++++++++
 tb/tb_arbitru_sram.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/memorie_pkg.sv
// memorie_pkg: shared states, port ids and default widths
// for the arbitru_sram SRAM arbiter (option: ARB_FIXED_PRIO_EN).
package memorie_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_HOLD
  } state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 8;

endpackage

// File: rtl/arbitru_rr.sv
// arbitru_rr: two-input grant picker for arbitru_sram.
// ARB_FIXED_PRIO_EN: port A always wins ties (B may starve).
module arbitru_rr (
  input  logic i_req_a,
  input  logic i_req_b,
`ifndef ARB_FIXED_PRIO_EN
  input  logic i_last_grant,
`endif
  output logic o_valid,
  output logic o_grant
);
  import memorie_pkg::*;

  logic w_tie_win;

`ifdef ARB_FIXED_PRIO_EN
  assign w_tie_win = PORT_A;
`else
  assign w_tie_win = ~i_last_grant;
`endif

  // pick the winner; a lone request always wins
  always_comb begin
    o_valid = i_req_a | i_req_b;
    o_grant = PORT_A;
    unique case (1'b1)
      (i_req_a && i_req_b):  o_grant = w_tie_win;
      (i_req_a && !i_req_b): o_grant = PORT_A;
      (!i_req_a && i_req_b): o_grant = PORT_B;
      default:               o_grant = PORT_A;
    endcase
  end

endmodule

// File: rtl/arbitru_sram.sv
// arbitru_sram: two-port arbiter/sequencer owning all strobes
// of a shared async SRAM (option: ARB_FIXED_PRIO_EN).
module arbitru_sram #(
  parameter int ADDR_W      = memorie_pkg::ADDR_W,
  parameter int DATA_W      = memorie_pkg::DATA_W,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic              ack_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              ack_b,
  output logic [DATA_W-1:0] rdata_b,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_data,
  output logic              sram_ce_n,
  output logic              sram_we_n,
  output logic              sram_oe_n,
  output logic              busy
);
  import memorie_pkg::*;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t            r_state;
  logic              r_port;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_cnt;
  logic              r_ce_n;
  logic              r_we_n;
  logic              r_oe_n;
  logic              r_drive;
  logic              r_ack_a;
  logic              r_ack_b;
  logic [DATA_W-1:0] r_rdata_a;
  logic [DATA_W-1:0] r_rdata_b;

  logic              w_valid;
  logic              w_grant;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

`ifndef ARB_FIXED_PRIO_EN
  logic              r_last;
`endif

  arbitru_rr u_rr (
    .i_req_a      (req_a),
    .i_req_b      (req_b),
`ifndef ARB_FIXED_PRIO_EN
    .i_last_grant (r_last),
`endif
    .o_valid      (w_valid),
    .o_grant      (w_grant)
  );

  assign w_sel_we    = (w_grant == PORT_B) ? we_b    : we_a;
  assign w_sel_addr  = (w_grant == PORT_B) ? addr_b  : addr_a;
  assign w_sel_wdata = (w_grant == PORT_B) ? wdata_b : wdata_a;

`ifndef ARB_FIXED_PRIO_EN
  // remember the last winner so ties alternate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_last <= PORT_B;
    else if (r_state == S_IDLE && w_valid)
      r_last <= w_grant;
  end
`endif

  // sequencer: IDLE -> SETUP -> ACCESS xN -> HOLD -> IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_port    <= PORT_A;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_cnt     <= '0;
      r_ce_n    <= 1'b1;
      r_we_n    <= 1'b1;
      r_oe_n    <= 1'b1;
      r_drive   <= 1'b0;
      r_ack_a   <= 1'b0;
      r_ack_b   <= 1'b0;
      r_rdata_a <= '0;
      r_rdata_b <= '0;
    end else begin
      r_ack_a <= 1'b0;
      r_ack_b <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_valid) begin
            r_port  <= w_grant;
            r_we    <= w_sel_we;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_ce_n  <= 1'b0;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_cnt   <= CNT_LOAD;
          r_we_n  <= ~r_we;
          r_oe_n  <= r_we;
          r_drive <= r_we;
          r_state <= S_ACCESS;
        end
        S_ACCESS: begin
          if (r_cnt == 4'd0) begin
            r_we_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_state <= S_HOLD;
            if (r_port == PORT_A) begin
              r_ack_a <= 1'b1;
              if (!r_we)
                r_rdata_a <= sram_data;
            end else begin
              r_ack_b <= 1'b1;
              if (!r_we)
                r_rdata_b <= sram_data;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_HOLD: begin
          r_ce_n  <= 1'b1;
          r_drive <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sram_data = r_drive ? r_wdata : {DATA_W{1'bz}};
  assign sram_addr = r_addr;
  assign sram_ce_n = r_ce_n;
  assign sram_we_n = r_we_n;
  assign sram_oe_n = r_oe_n;
  assign ack_a     = r_ack_a;
  assign ack_b     = r_ack_b;
  assign rdata_a   = r_rdata_a;
  assign rdata_b   = r_rdata_b;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_arbitru_sram.sv
// tb_arbitru_sram: random two-port traffic against a
// latency/round-robin reference model with a scoreboard.
module tb_arbitru_sram;

  localparam int W = 3;
`ifdef ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  typedef struct {
    int         port;
    logic       we;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    int         g;
  } txn_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_a, we_a, req_b, we_b;
  logic [2:0] addr_a, addr_b;
  logic [7:0] wdata_a, wdata_b;
  logic       ack_a, ack_b;
  logic [7:0] rdata_a, rdata_b;
  logic [2:0] sram_addr;
  wire  [7:0] sram_data;
  logic       sram_ce_n, sram_we_n, sram_oe_n, busy;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;

  logic       rq [2];
  logic       wq [2];
  logic [2:0] aq [2];
  logic [7:0] dq [2];
  bit         pend [2];
  int         gq [2];
  int         last;
  int         next_free;
  logic [7:0] ref_mem [8];
  logic [7:0] exp_rd [2];
  txn_t       sb [$];

  logic [7:0] mem [8];

  always #5 clk = ~clk;

  arbitru_sram #(.ADDR_W(3), .DATA_W(8), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a),
    .wdata_a(wdata_a), .ack_a(ack_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b),
    .wdata_b(wdata_b), .ack_b(ack_b), .rdata_b(rdata_b),
    .sram_addr(sram_addr), .sram_data(sram_data),
    .sram_ce_n(sram_ce_n), .sram_we_n(sram_we_n),
    .sram_oe_n(sram_oe_n), .busy(busy)
  );

  assign sram_data =
    (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem[sram_addr] : 8'bz;

  always @(negedge clk)
    if (rst_n && !sram_ce_n && !sram_we_n)
      mem[sram_addr] <= sram_data;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic drive();
    req_a = rq[0]; we_a = wq[0]; addr_a = aq[0]; wdata_a = dq[0];
    req_b = rq[1]; we_b = wq[1]; addr_b = aq[1]; wdata_b = dq[1];
  endtask

  task automatic model_reset();
    last = 1;
    next_free = 0;
    sb.delete();
    exp_rd[0] = 8'h00;
    exp_rd[1] = 8'h00;
    for (int p = 0; p < 2; p++) begin
      rq[p] = 1'b0; wq[p] = 1'b0; aq[p] = 3'd0; dq[p] = 8'd0;
      pend[p] = 1'b0; gq[p] = -10;
    end
  endtask

  task automatic model();
    txn_t t;
    int   w;
    if (cyc >= next_free && (rq[0] || rq[1])) begin
      if (rq[0] && rq[1]) w = FIXED ? 0 : ((last == 0) ? 1 : 0);
      else w = rq[0] ? 0 : 1;
      t.port = w; t.we = wq[w]; t.addr = aq[w]; t.wdata = dq[w];
      t.g = cyc;
      if (t.we) begin
        t.rdata = 8'h00;
        ref_mem[t.addr] = t.wdata;
      end else begin
        t.rdata = ref_mem[t.addr];
      end
      sb.push_back(t);
      last = w;
      next_free = cyc + 3 + W;
      gq[w] = cyc;
      pend[w] = 1'b0;
    end
  endtask

  // mode 0 random, 1 both held high, 2 quiet
  task automatic step(input int mode);
    @(posedge clk);
    #1;
    cyc++;
    for (int p = 0; p < 2; p++) begin
      if (!(rq[p] && pend[p]) && cyc >= gq[p] + 2) begin
        rq[p] = (mode == 1) ? 1'b1 :
                (mode == 0) ? ($urandom_range(0, 2) == 0) : 1'b0;
        wq[p] = 1'($urandom_range(0, 1));
        aq[p] = 3'($urandom_range(0, 7));
        dq[p] = 8'($urandom);
        pend[p] = rq[p];
      end
    end
    drive();
    model();
  endtask

  task automatic mon();
    txn_t       t;
    logic [5:0] e;
    bit         act, drv, rd;
    int         c;
    c = cyc;
    e = 6'b111000;
    act = 0; drv = 0; rd = 0;
    if (sb.size() > 0) begin
      t = sb[0];
      if (c >= t.g + 1 && c <= t.g + 2 + W) begin
        act = 1;
        e[5] = 1'b0;
        e[2] = 1'b1;
        if (c >= t.g + 2 && c <= t.g + 1 + W) begin
          if (t.we) e[4] = 1'b0;
          else begin e[3] = 1'b0; rd = 1; end
        end
        if (c == t.g + 2 + W) begin
          if (t.port == 0) e[1] = 1'b1;
          else e[0] = 1'b1;
        end
        drv = t.we && c >= t.g + 2 && c <= t.g + 2 + W;
      end
    end
    chk("strobes{ce,we,oe,busy,acka,ackb}",
        32'({sram_ce_n, sram_we_n, sram_oe_n, busy, ack_a, ack_b}),
        32'(e));
    if (act) chk("sram_addr", 32'(sram_addr), 32'(t.addr));
    if (drv) chk("bus_wdata", 32'(sram_data), 32'(t.wdata));
    else if (rd) chk("bus_rdata", 32'(sram_data), 32'(t.rdata));
    else chk("bus_z", 32'(sram_data), {24'd0, 8'bz});
    chk("we_oe_exclusive", 32'(sram_we_n | sram_oe_n), 32'd1);
    chk("ack_exclusive", 32'(ack_a & ack_b), 32'd0);
    if (ack_a || ack_b) begin
      if (sb.size() == 0) begin
        chk("ack_unexpected", 32'({ack_a, ack_b}), 32'd0);
      end else begin
        t = sb.pop_front();
        chk("ack_port", ack_b ? 32'd1 : 32'd0, 32'(t.port));
        chk("ack_cycle", 32'(c), 32'(t.g + 2 + W));
        if (!t.we) exp_rd[t.port] = t.rdata;
        chk("rdata_a", 32'(rdata_a), 32'(exp_rd[0]));
        chk("rdata_b", 32'(rdata_b), 32'(exp_rd[1]));
      end
    end
  endtask

  always @(negedge clk)
    if (mon_en) mon();

  task automatic chk_reset(string tag);
    chk({tag, "_ce_n"}, 32'(sram_ce_n), 32'd1);
    chk({tag, "_we_n"}, 32'(sram_we_n), 32'd1);
    chk({tag, "_oe_n"}, 32'(sram_oe_n), 32'd1);
    chk({tag, "_addr"}, 32'(sram_addr), 32'd0);
    chk({tag, "_bus"}, 32'(sram_data), {24'd0, 8'bz});
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_acks"}, 32'({ack_a, ack_b}), 32'd0);
    chk({tag, "_rdata_a"}, 32'(rdata_a), 32'd0);
    chk({tag, "_rdata_b"}, 32'(rdata_b), 32'd0);
  endtask

  initial begin
    logic [7:0] saved;
    int         g;
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    model_reset();
    drive();
    repeat (3) @(posedge clk);
    #1;
    chk_reset("por");
    rst_n = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < 200; i++) step(1);
    for (int i = 0; i < 1500; i++) step(0);
    for (int i = 0; i < 40; i++) step(2);

    // directed write A: addr 6 <= A5
    rq[0] = 1'b1; wq[0] = 1'b1; aq[0] = 3'd6; dq[0] = 8'hA5;
    pend[0] = 1'b1;
    step(2);
    for (int i = 0; i < 8; i++) step(2);
    // directed read B from addr 6
    rq[1] = 1'b1; wq[1] = 1'b0; aq[1] = 3'd6; dq[1] = 8'h00;
    pend[1] = 1'b1;
    step(2);
    for (int i = 0; i < 8; i++) step(2);

    // write A, then reset during ACCESS
    saved = ref_mem[2];
    rq[0] = 1'b1; wq[0] = 1'b1; aq[0] = 3'd2; dq[0] = 8'h3C;
    pend[0] = 1'b1;
    step(2);
    g = cyc;
    while (cyc < g + 2) step(2);
    mon_en = 1'b0;
    chk("pre_reset_we_n", 32'(sram_we_n), 32'd0);
    rst_n = 1'b0;
    #1;
    chk_reset("async");
    ref_mem[2] = saved;
    model_reset();
    drive();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_acks", 32'({ack_a, ack_b}), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 3; i++) step(2);
    for (int i = 0; i < 60; i++) step(1);

    for (int i = 0; i < 100 && (sb.size() > 0 || cyc < next_free); i++)
      step(2);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    mon_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
